ri5cy_mem_arbiter: RTL and testbench
====================================

# ri5cy_mem_arbiter

Two-requester arbiter sharing one RI5CY-protocol memory port (req/gnt/rvalid) between the core's instruction and data interfaces. Sits between the RI5CY core and the single RI5CY-to-AHB bridge, so both core ports reach the AHB fabric through one master. Provides round-robin arbitration, keeps a stalled request stable until it is granted, and tracks outstanding transfers so each response returns to the port that issued it.

## Interface
- MAX_OUTSTANDING, 2: accepted transfers awaiting rvalid; power of two, ≥1.
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- m0_req_i / m1_req_i  in  1  requests; m0 = instruction, m1 = data.
- m0_we_i / m1_we_i  in  1  write enable (m0 tied 0 at top level).
- m0_be_i / m1_be_i  in  4  byte enables.
- m0_addr_i / m1_addr_i  in  32  address.
- m0_wdata_i / m1_wdata_i  in  32  write data.
- m0_gnt_o / m1_gnt_o  out  1  grant.
- m0_rvalid_o / m1_rvalid_o  out  1  response valid.
- m0_rdata_o / m1_rdata_o  out  32  read data.
- s_req_o, s_we_o, s_be_o[3:0], s_addr_o[31:0], s_wdata_o[31:0]  out  downstream request to bridge.
- s_gnt_i  in  1  downstream grant.
- s_rvalid_i  in  1  downstream response valid.
- s_rdata_i  in  32  downstream read data.
- err_o  out  1  sticky protocol error (rvalid with nothing outstanding).

## Operation
- FSM: ARB, HOLD. Reset → ARB.
- ARB: if exactly one m*_req_i high, select it; if both, select port ≠ last_grant. Selected fields muxed to s_*; s_req_o = selected req & ~full_block.
- Accept = s_req_o & s_gnt_i. Accept → selected m*_gnt_o = 1, push port id into owner FIFO, last_grant ← id, stay ARB.
- s_req_o high without s_gnt_i → HOLD with sel latched; HOLD keeps same port regardless of other requester until accept, then → ARB.
- Requester drops req in HOLD (protocol violation): → ARB next cycle, no push.
- full_block = FIFO full & ~s_rvalid_i (pop in same cycle frees a slot; simultaneous push and pop when full allowed).
- s_rvalid_i: pop head id; drive that port's m*_rvalid_o = 1; s_rdata_i broadcast to both m*_rdata_o.
- s_rvalid_i with FIFO empty: ignored (no m*_rvalid_o), err_o ← 1 until reset.
- Non-selected port: gnt_o = 0.

## Timing
- Zero-latency combinational paths: m*_req→s_req_o, s_gnt_i→m*_gnt_o, s_rvalid_i→m*_rvalid_o. No registers on datapath.
- Reset values: FSM=ARB, last_grant=1 (m0 wins first tie), FIFO empty, err_o=0; m*_gnt_o / m*_rvalid_o low whenever their inputs are low.
- Throughput: one accept per cycle sustained when s_gnt_i held high, FIFO not blocking.
- Ordering: responses strictly in accept order (FIFO).
- Reset asserted mid-transfer: FIFO cleared, outstanding responses discarded; any later s_rvalid_i raises err_o.

## Structure
- Package ri5cy_arb_pkg: arb state enum {ARB, HOLD}, port-id typedef (1 bit), localparams for port indices.
- Sub-module ri5cy_arb_owner_fifo: DEPTH=MAX_OUTSTANDING, 1-bit payload, push/pop/full/empty, pointer wrap, count width $clog2(DEPTH)+1, simultaneous push+pop when full or empty legal.
- Top: FSM, round-robin pointer, muxes, response demux, err flag.

## Test plan
- Single m1 read 0x8000_0010, s_gnt_i=1, s_rvalid_i next cycle with 0xDEADBEEF → m1_gnt_o 1 cycle, m1_rvalid_o next cycle, m1_rdata_o=0xDEADBEEF, m0_rvalid_o stays 0.
- Both req held 6 cycles, s_gnt_i=1, rvalid each following cycle → grants alternate m0,m1,m0,m1,m0,m1; rvalids follow same order.
- m0 req with s_gnt_i=0 for 3 cycles, m1 req from cycle 1 → s_addr_o stays m0's address, m0 granted cycle 3, m1 granted cycle 4.
- MAX_OUTSTANDING=2, two accepts without rvalid → s_req_o low on third; rvalid+third request same cycle → third accepted that cycle.
- s_rvalid_i pulse after reset with nothing outstanding → no m*_rvalid_o, err_o=1 and stays until rstn low.
- rstn low with one transfer outstanding, then rvalid → FIFO empty, err_o=1, next request wins as m0 on tie.

Source files
------------

// File: rtl/ri5cy_arb_pkg.sv
// Shared types for the RI5CY instruction/data memory-port arbiter.
package ri5cy_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_M0 = 1'b0;
    localparam port_id_t PORT_M1 = 1'b1;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/ri5cy_arb_owner_fifo.sv
// Owner-id FIFO: records which port issued each accepted transfer so responses
// can be routed back in order. Push and pop in the same cycle are legal at any fill level.
module ri5cy_arb_owner_fifo
    import ri5cy_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push_i,
    input  port_id_t data_i,
    input  logic     pop_i,
    output port_id_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ri5cy_mem_arbiter.sv
// Round-robin arbiter sharing one RI5CY req/gnt/rvalid port between the core's
// instruction (m0) and data (m1) interfaces; responses return to their issuer.
module ri5cy_mem_arbiter
    import ri5cy_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        err_o
);

    arb_state_e state_q, state_d;
    port_id_t   sel_q, sel_d, last_q, last_d, sel, head;
    logic       err_q, err_d;
    logic       sel_req, full_block, accept, pop;
    logic       fifo_full, fifo_empty;
    mem_req_t   m0_pl, m1_pl, s_pl;

    assign m0_pl = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign m1_pl = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

    // Port selection: HOLD pins the stalled port, ARB is round-robin on ties.
    always_comb begin
        sel = sel_q;
        if (state_q == ARB) begin
            if (m0_req_i && m1_req_i) begin
                sel = ~last_q;
            end else if (m1_req_i) begin
                sel = PORT_M1;
            end else begin
                sel = PORT_M0;
            end
        end
        sel_req = (sel == PORT_M1) ? m1_req_i : m0_req_i;
    end

    assign s_pl       = (sel == PORT_M1) ? m1_pl : m0_pl;
    assign full_block = fifo_full & ~s_rvalid_i;
    assign s_req_o    = sel_req & ~full_block;
    assign s_we_o     = s_pl.we;
    assign s_be_o     = s_pl.be;
    assign s_addr_o   = s_pl.addr;
    assign s_wdata_o  = s_pl.wdata;

    assign accept   = s_req_o & s_gnt_i;
    assign m0_gnt_o = accept & (sel == PORT_M0);
    assign m1_gnt_o = accept & (sel == PORT_M1);

    // Responses with nothing outstanding are dropped and flagged.
    assign pop         = s_rvalid_i & ~fifo_empty;
    assign m0_rvalid_o = pop & (head == PORT_M0);
    assign m1_rvalid_o = pop & (head == PORT_M1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = err_q;

    ri5cy_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (accept),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        err_d   = err_q | (s_rvalid_i & fifo_empty);
        if (accept) begin
            last_d = sel;
        end
        case (state_q)
            ARB: begin
                if (s_req_o && !s_gnt_i) begin
                    state_d = HOLD;
                    sel_d   = sel;
                end
            end
            HOLD: begin
                // A requester withdrawing mid-stall releases the lock without a push.
                if (accept || !sel_req) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB;
            sel_q   <= PORT_M0;
            last_q  <= PORT_M1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ri5cy_mem_arbiter.sv
// Bench for ri5cy_mem_arbiter: directed vector table, hand-written stall/error/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_ri5cy_mem_arbiter;

    localparam int MAXO = 2;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i, err_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ri5cy_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .err_o(err_o)
    );

    typedef struct {
        logic        r0, r1, g, rv;
        logic [31:0] rd;
        logic        sreq, g0, g1, v0, v1;
        logic [31:0] addr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
    task automatic step(input logic r0, input logic r1, input logic g, input logic rv,
                        input logic [31:0] rd);
        @(negedge clk);
        m0_req_i = r0; m1_req_i = r1; s_gnt_i = g; s_rvalid_i = rv; s_rdata_i = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
        m0_addr_i = A0; m1_addr_i = A1; m0_we_i = 1'b0; m1_we_i = 1'b0;
        m0_be_i = 4'hF; m1_be_i = 4'hF; m0_wdata_i = '0; m1_wdata_i = '0; s_rdata_i = '0;
        #1;
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_sreq", 32'(s_req_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic sreq, input logic g0, input logic g1,
                           input logic v0, input logic v1);
        chk({tag, "_sreq"}, 32'(s_req_o), 32'(sreq));
        chk({tag, "_g0"}, 32'(m0_gnt_o), 32'(g0));
        chk({tag, "_g1"}, 32'(m1_gnt_o), 32'(g1));
        chk({tag, "_v0"}, 32'(m0_rvalid_o), 32'(v0));
        chk({tag, "_v1"}, 32'(m1_rvalid_o), 32'(v1));
    endtask

    vec_t tbl[15];

    // Reference model state
    int q[$];
    int last_m, pend;
    bit err_m;

    initial begin
        // single m1 read, alternating ties, full-FIFO blocking with same-cycle pop
        tbl[0]  = '{0,1,1,0,32'h0,         1,0,1,0,0, A1};
        tbl[1]  = '{0,0,1,1,32'hDEADBEEF,  0,0,0,0,1, A0};
        tbl[2]  = '{1,1,1,0,32'h0,         1,1,0,0,0, A0};
        tbl[3]  = '{1,1,1,1,32'h11111111,  1,0,1,1,0, A1};
        tbl[4]  = '{1,1,1,1,32'h22222222,  1,1,0,0,1, A0};
        tbl[5]  = '{1,1,1,1,32'h33333333,  1,0,1,1,0, A1};
        tbl[6]  = '{1,1,1,1,32'h44444444,  1,1,0,0,1, A0};
        tbl[7]  = '{1,1,1,1,32'h55555555,  1,0,1,1,0, A1};
        tbl[8]  = '{0,0,0,1,32'h66666666,  0,0,0,0,1, A0};
        tbl[9]  = '{1,0,1,0,32'h0,         1,1,0,0,0, A0};
        tbl[10] = '{1,0,1,0,32'h0,         1,1,0,0,0, A0};
        tbl[11] = '{0,1,1,0,32'h0,         0,0,0,0,0, A1};
        tbl[12] = '{0,1,1,1,32'h77777777,  1,0,1,1,0, A1};
        tbl[13] = '{0,0,0,1,32'h88888888,  0,0,0,1,0, A0};
        tbl[14] = '{0,0,0,1,32'h99999999,  0,0,0,0,1, A0};

        rstn = 1'b0;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r0, tbl[i].r1, tbl[i].g, tbl[i].rv, tbl[i].rd);
            chk_out($sformatf("vec%0d", i), tbl[i].sreq, tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1);
            if (tbl[i].sreq) chk($sformatf("vec%0d_addr", i), s_addr_o, tbl[i].addr);
            if (tbl[i].rv) begin
                chk($sformatf("vec%0d_rd0", i), m0_rdata_o, tbl[i].rd);
                chk($sformatf("vec%0d_rd1", i), m1_rdata_o, tbl[i].rd);
            end
            chk($sformatf("vec%0d_err", i), 32'(err_o), 32'd0);
        end

        // stall: m0 held for 3 cycles while m1 also asks; address must stay m0's
        do_reset();
        step(1, 0, 0, 0, 0); chk_out("hold0", 1, 0, 0, 0, 0); chk("hold0_addr", s_addr_o, A0);
        step(1, 1, 0, 0, 0); chk_out("hold1", 1, 0, 0, 0, 0); chk("hold1_addr", s_addr_o, A0);
        step(1, 1, 0, 0, 0); chk_out("hold2", 1, 0, 0, 0, 0); chk("hold2_addr", s_addr_o, A0);
        step(1, 1, 1, 0, 0); chk_out("hold3", 1, 1, 0, 0, 0); chk("hold3_addr", s_addr_o, A0);
        step(0, 1, 1, 0, 0); chk_out("hold4", 1, 0, 1, 0, 0); chk("hold4_addr", s_addr_o, A1);
        step(0, 0, 0, 1, 1); chk_out("hold5", 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 2); chk_out("hold6", 0, 0, 0, 0, 1);

        // held requester withdraws: lock released, nothing offered that cycle
        step(0, 1, 0, 0, 0); chk_out("drop0", 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0); chk_out("drop1", 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0); chk_out("drop2", 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 3); chk_out("drop3", 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0); chk("drop_err", 32'(err_o), 32'd0);

        // stray response: dropped, error sticks until reset
        do_reset();
        step(0, 0, 0, 1, 32'h1234); chk_out("stray0", 0, 0, 0, 0, 0);
        chk("stray0_err", 32'(err_o), 32'd0);
        step(0, 0, 0, 0, 0); chk("stray1_err", 32'(err_o), 32'd1);
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("stray3_err", 32'(err_o), 32'd1);

        // reset with a transfer outstanding discards it
        do_reset();
        step(0, 1, 1, 0, 0); chk_out("mid0", 1, 0, 1, 0, 0);
        do_reset();
        step(0, 0, 0, 1, 32'h5555); chk_out("mid1", 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0); chk_out("mid2", 1, 1, 0, 0, 0);
        chk("mid2_err", 32'(err_o), 32'd1);
        chk("mid2_addr", s_addr_o, A0);

        // randomized traffic against the reference model
        do_reset();
        q.delete(); last_m = 1; pend = -1; err_m = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic r0, r1, g, rv, offered, acc, blocked;
            int cand, head;
            r0 = ($urandom_range(0, 9) < 6);
            r1 = ($urandom_range(0, 9) < 6);
            if (pend == 0 && $urandom_range(0, 9) < 9) r0 = 1'b1;
            if (pend == 1 && $urandom_range(0, 9) < 9) r1 = 1'b1;
            g  = 1'($urandom_range(0, 1));
            rv = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            m0_req_i = r0; m1_req_i = r1; s_gnt_i = g; s_rvalid_i = rv;
            s_rdata_i = $urandom;
            m0_addr_i = $urandom; m0_wdata_i = $urandom; m0_be_i = 4'($urandom); m0_we_i = 1'b0;
            m1_addr_i = $urandom; m1_wdata_i = $urandom; m1_be_i = 4'($urandom);
            m1_we_i = 1'($urandom_range(0, 1));
            #1;

            cand = -1;
            if (pend >= 0) cand = ((pend == 0) ? r0 : r1) ? pend : -1;
            else if (r0 && r1) cand = 1 - last_m;
            else if (r0) cand = 0;
            else if (r1) cand = 1;
            blocked = (q.size() == MAXO) && !rv;
            offered = (cand >= 0) && !blocked;
            acc     = offered && g;
            head    = (rv && q.size() > 0) ? q[0] : -1;

            chk_out("rnd", offered, acc && cand == 0, acc && cand == 1, head == 0, head == 1);
            chk("rnd_err", 32'(err_o), 32'(err_m));
            if (offered) begin
                chk("rnd_addr", s_addr_o, (cand == 0) ? m0_addr_i : m1_addr_i);
                chk("rnd_wdata", s_wdata_o, (cand == 0) ? m0_wdata_i : m1_wdata_i);
                chk("rnd_be", 32'(s_be_o), 32'((cand == 0) ? m0_be_i : m1_be_i));
                chk("rnd_we", 32'(s_we_o), 32'((cand == 0) ? m0_we_i : m1_we_i));
            end
            if (rv) chk("rnd_rdata", m1_rdata_o, s_rdata_i);

            if (rv && q.size() == 0) err_m = 1'b1;
            if (head >= 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(cand);
                last_m = cand;
                pend   = -1;
            end else if (offered) begin
                pend = cand;
            end else if (pend >= 0 && cand < 0) begin
                pend = -1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
